// File: rtl/event_fifo_drain_pkg.sv
// Shared definitions for the event-monitor read-side blocks: widths, beat math
// and the drain FSM state encoding.
package ea_mon_pkg;

  localparam int unsigned EVT_W     = 72;
  localparam int unsigned OUT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } drain_state_e;

  // Number of ow-bit beats needed to carry a w-bit record (ceiling division).
  function automatic int unsigned beats_f(input int unsigned w, input int unsigned ow);
    return (w + ow - 1) / ow;
  endfunction

endpackage

// File: rtl/event_fifo_drain_if.sv
// Narrow valid/ready beat stream carrying serialised event records.
interface event_fifo_drain_if
  import ea_mon_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEF
) ();

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/event_fifo_drain.sv
// Pops event records from the synchronous event FIFO and serialises each one
// LSB-chunk first onto the narrow beat stream, marking the final beat.
module event_fifo_drain
  import ea_mon_pkg::*;
#(
  parameter int unsigned W     = EVT_W,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               fifo_empty,
  output logic               fifo_pop,
  input  logic [W-1:0]       fifo_data,
  event_fifo_drain_if.master out_if,
  output logic               busy,
  output logic [CNT_W-1:0]   frames_sent
);

  localparam int unsigned BEATS = beats_f(W, OUT_W);
  localparam int unsigned SH_W  = BEATS * OUT_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  drain_state_e     state_q, state_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] frames_sent_q, frames_sent_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             pop_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      beat_q        <= '0;
      frames_sent_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      beat_q        <= beat_d;
      frames_sent_q <= frames_sent_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, shift/beat bookkeeping and pop decision
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    beat_d        = beat_q;
    frames_sent_d = frames_sent_q;
    pop_c         = 1'b0;

    case (state_q)
      IDLE: begin
        pop_c = enable & ~fifo_empty;
        if (pop_c) state_d = LOAD;
      end
      LOAD: begin
        sh_d    = SH_W'(fifo_data);
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_valid_q && out_if.out_ready) begin
          sh_d = sh_q >> OUT_W;
          if (beat_q == LAST_IDX) begin
            if (frames_sent_q != '1) frames_sent_d = frames_sent_q + CNT_W'(1);
            beat_d  = '0;
            // Back-to-back records: the next pop overlaps the final handshake.
            pop_c   = enable & ~fifo_empty;
            state_d = pop_c ? LOAD : IDLE;
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == SEND);
    out_data_d  = out_valid_d ? sh_d[OUT_W-1:0] : '0;
    out_last_d  = out_valid_d && (beat_d == LAST_IDX);
    busy_d      = (state_d != IDLE);
  end

  // Pop is held off while reset is asserted so the FIFO never sees a stray read.
  assign fifo_pop         = pop_c & rst_n;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign frames_sent      = frames_sent_q;

endmodule

// File: tb/tb_event_fifo_drain.sv
// Scoreboard bench for event_fifo_drain: a behavioural FIFO feeds records while a
// negedge monitor checks every accepted beat against the expected-beat queue.
module tb_event_fifo_drain;
  import ea_mon_pkg::*;

  localparam int unsigned W     = 72;
  localparam int unsigned OW    = 8;
  localparam int unsigned CW    = 16;
  localparam int unsigned BEATS = 9;

  typedef struct packed {
    logic          last;
    logic [OW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [W-1:0]  fifo_data;
  logic          busy;
  logic [CW-1:0] frames_sent;

  event_fifo_drain_if #(.OUT_W(OW)) out_if ();

  event_fifo_drain #(.W(W), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .out_if     (out_if),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural FIFO: one-cycle read latency, separate push/pop counters.
  logic [W-1:0] fifo_mem [64];
  int unsigned  push_cnt = 0;
  int unsigned  pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_pop) begin
      check("pop_not_empty", fifo_empty, 1'b0);
      fifo_data <= fifo_mem[pop_cnt % 64];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  beat_t         exp_q [$];
  logic [OW-1:0] log_q [$];

  // Monitor state
  int            cyc        = 0;
  int            acc_cnt    = 0;
  int            mon_idx    = 0;
  int            last_cyc   = 0;
  logic          last_valid = 1'b0;
  logic          gap_chk    = 1'b0;
  logic          stall_q    = 1'b0;
  logic [OW-1:0] st_data;
  logic          st_last;
  beat_t         e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("pop_in_reset", fifo_pop, 1'b0);
      // A partially sent record is abandoned by reset.
      if (mon_idx != 0) begin
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.last) break;
        end
      end
      mon_idx    = 0;
      stall_q    = 1'b0;
      last_valid = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", out_if.out_valid, 1'b1);
        check("stall_data", out_if.out_data, st_data);
        check("stall_last", out_if.out_last, st_last);
      end
      if (out_if.out_valid && out_if.out_ready) begin
        acc_cnt++;
        log_q.push_back(out_if.out_data);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_beat: actual=%0h required=no beat", out_if.out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_if.out_data, e.data);
          check("beat_last", out_if.out_last, e.last);
          if (mon_idx == 0 && gap_chk && last_valid) check("frame_gap", cyc - last_cyc - 1, 1);
          if (e.last) begin
            last_cyc   = cyc;
            last_valid = gap_chk;
            mon_idx    = 0;
          end else begin
            mon_idx++;
          end
        end
      end
      stall_q = out_if.out_valid && !out_if.out_ready;
      st_data = out_if.out_data;
      st_last = out_if.out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [W-1:0] r);
    fifo_mem[push_cnt % 64] = r;
    for (int b = 0; b < BEATS; b++)
      exp_q.push_back(beat_t'{last: (b == BEATS - 1), data: r[b*OW +: OW]});
    push_cnt++;
  endtask

  task automatic wait_frames(input string name, input logic [CW-1:0] tgt, input int max);
    int n = 0;
    while (!(frames_sent == tgt && !busy) && n < max) begin
      step();
      n++;
    end
    check(name, frames_sent, tgt);
  endtask

  task automatic wait_beats(input string name, input int tgt, input int max);
    int n = 0;
    while (acc_cnt < tgt && n < max) begin
      step();
      n++;
    end
    check(name, acc_cnt, tgt);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned   p0;
    int            a0;
    int            l0;
    logic [OW-1:0] t1b [9];
    logic          pat [4];
    t1b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAB};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n            = 1'b0;
    enable           = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_data", out_if.out_data, 8'h00);
    check("rst_last", out_if.out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frames_sent, 16'h0000);
    rst_n = 1'b1;
    step();
    enable = 1'b1;

    // Single record, always-ready sink
    p0 = pop_cnt;
    l0 = log_q.size();
    push_rec(72'hAB_8877_6655_4433_2211);
    wait_frames("t1_frames", 16'd1, 100);
    check("t1_beats", log_q.size() - l0, 9);
    for (int i = 0; i < 9; i++) check("t1_byte", log_q[l0 + i], t1b[i]);
    check("t1_pops", pop_cnt - p0, 1);

    // Three back-to-back records
    p0      = pop_cnt;
    gap_chk = 1'b1;
    push_rec(72'h19_1817_1615_1413_1211);
    push_rec(72'h29_2827_2625_2423_2221);
    push_rec(72'h39_3837_3635_3433_3231);
    wait_frames("t2_frames", 16'd4, 200);
    gap_chk = 1'b0;
    check("t2_pops", pop_cnt - p0, 3);
    check("t2_empty", fifo_empty, 1'b1);
    check("t2_expq", exp_q.size(), 0);

    // Sink stalls with a 1,0,0,1 ready pattern
    push_rec(72'hC3_5AA5_F00F_0102_FE80);
    for (int k = 0; k < 200 && !(frames_sent == 16'd5 && !busy); k++) begin
      out_if.out_ready = pat[k % 4];
      step();
    end
    out_if.out_ready = 1'b1;
    check("t3_frames", frames_sent, 16'd5);
    check("t3_expq", exp_q.size(), 0);

    // Disabled drain must leave the FIFO alone
    enable = 1'b0;
    p0     = pop_cnt;
    push_rec(72'h49_4847_4645_4443_4241);
    push_rec(72'h59_5857_5655_5453_5251);
    repeat (20) step();
    check("t4_nopop", pop_cnt - p0, 0);
    check("t4_busy", busy, 1'b0);
    check("t4_frames", frames_sent, 16'd5);
    // Dropping enable mid-frame still finishes that frame only
    enable = 1'b1;
    a0     = acc_cnt;
    wait_beats("t4_beat4", a0 + 4, 100);
    enable = 1'b0;
    wait_frames("t4_frames_a", 16'd6, 100);
    repeat (5) step();
    check("t4_pops_a", pop_cnt - p0, 1);
    check("t4_left", exp_q.size(), 9);
    check("t4_fifo_ne", fifo_empty, 1'b0);
    check("t4_idle", busy, 1'b0);
    enable = 1'b1;
    wait_frames("t4_frames_b", 16'd7, 100);
    check("t4_pops_b", pop_cnt - p0, 2);

    // Reset in the middle of a frame
    push_rec(72'h69_6867_6665_6463_6261);
    push_rec(72'h79_7877_7675_7473_7271);
    a0 = acc_cnt;
    wait_beats("t5_beat5", a0 + 5, 100);
    rst_n = 1'b0;
    #1;
    check("t5_valid", out_if.out_valid, 1'b0);
    check("t5_data", out_if.out_data, 8'h00);
    check("t5_last", out_if.out_last, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_frames", frames_sent, 16'h0000);
    check("t5_pop", fifo_pop, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    wait_frames("t5_frames_after", 16'd1, 100);
    check("t5_expq", exp_q.size(), 0);
    check("t5_empty", fifo_empty, 1'b1);

    // Saturation of the frame counter
    force dut.frames_sent_q = 16'hFFFF;
    step();
    step();
    release dut.frames_sent_q;
    step();
    push_rec(72'h89_8887_8685_8483_8281);
    wait_idle("t6_drain", 100);
    check("t6_sat", frames_sent, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
